// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, architectural status encodings
// and the sequencer state type.
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [1:0] STAT_AOK = 2'd0;
    localparam logic [1:0] STAT_HLT = 2'd1;
    localparam logic [1:0] STAT_ADR = 2'd2;
    localparam logic [1:0] STAT_INS = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_MEMORY    = 3'd4,
        S_WRITEBACK = 3'd5,
        S_HALTED    = 3'd6
    } seq_state_t;

    // Instructions that touch data memory and therefore visit the MEMORY stage.
    function automatic logic uses_mem(input logic [3:0] code);
        case (code)
            I_RMMOVQ, I_MRMOVQ, I_CALL, I_RET, I_PUSHQ, I_POPQ: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/cond_eval.sv
// Combinational Y86-64 condition evaluation for JXX/CMOVXX from ifun and the
// condition-code flags.
module cond_eval
    import y86_pkg::*;
(
    input  logic [3:0] ifun,
    input  logic       zf,
    input  logic       sf,
    input  logic       ovf,
    output logic       cnd
);

    logic lt;

    assign lt = sf ^ ovf;

    always_comb begin
        cnd = 1'b0;
        case (ifun)
            4'd0:    cnd = 1'b1;
            4'd1:    cnd = lt | zf;
            4'd2:    cnd = lt;
            4'd3:    cnd = zf;
            4'd4:    cnd = !zf;
            4'd5:    cnd = !lt;
            4'd6:    cnd = !lt & !zf;
            default: cnd = 1'b0;
        endcase
    end

endmodule

// File: rtl/seq_controller.sv
// Multi-cycle Y86-64 sequencer: one stage enable per cycle, PC/status ownership,
// condition capture, data-memory wait states with timeout, performance counters.
module seq_controller
    import y86_pkg::*;
#(
    parameter logic [63:0] RESET_PC    = 64'h0,
    parameter int          MEM_TIMEOUT = 16,
    parameter int          CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [3:0]       icode,
    input  logic [3:0]       ifun,
    input  logic             instr_valid,
    input  logic             imem_error,
    input  logic             ZF,
    input  logic             SF,
    input  logic             OF,
    input  logic [63:0]      valC,
    input  logic [63:0]      valP,
    input  logic [63:0]      valM,
    input  logic             mem_ack,
    input  logic             dmem_error,
    output logic [63:0]      PC,
    output logic             f_en,
    output logic             d_en,
    output logic             e_en,
    output logic             m_en,
    output logic             w_en,
    output logic             setcc_en,
    output logic             mem_req,
    output logic             cnd,
    output logic [1:0]       status,
    output logic             halted,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instr_count
);

    localparam int TMO_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

    seq_state_t       state;
    seq_state_t       state_next;
    logic             cond_now;
    logic             cnd_load;
    logic             fault;
    logic [1:0]       fault_status;
    logic             tmo_clear;
    logic             tmo_inc;
    logic [TMO_W-1:0] tmo_cnt;
    logic             wb_commit;
    logic [63:0]      next_pc;

    cond_eval u_cond_eval (
        .ifun (ifun),
        .zf   (ZF),
        .sf   (SF),
        .ovf  (OF),
        .cnd  (cond_now)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        f_en         = 1'b0;
        d_en         = 1'b0;
        e_en         = 1'b0;
        m_en         = 1'b0;
        w_en         = 1'b0;
        setcc_en     = 1'b0;
        mem_req      = 1'b0;
        cnd_load     = 1'b0;
        fault        = 1'b0;
        fault_status = STAT_AOK;
        tmo_clear    = 1'b0;
        tmo_inc      = 1'b0;
        wb_commit    = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (run) state_next = S_FETCH;
            end
            S_FETCH: begin
                f_en = 1'b1;
                if (imem_error) begin
                    fault        = 1'b1;
                    fault_status = STAT_ADR;
                end else if (!instr_valid) begin
                    fault        = 1'b1;
                    fault_status = STAT_INS;
                end else if (icode == I_HALT) begin
                    fault        = 1'b1;
                    fault_status = STAT_HLT;
                end else begin
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                d_en       = 1'b1;
                state_next = S_EXECUTE;
            end
            S_EXECUTE: begin
                e_en     = 1'b1;
                setcc_en = (icode == I_OPQ);
                cnd_load = 1'b1;
                if (uses_mem(icode)) begin
                    state_next = S_MEMORY;
                    tmo_clear  = 1'b1;
                end else begin
                    state_next = S_WRITEBACK;
                end
            end
            S_MEMORY: begin
                m_en    = 1'b1;
                mem_req = 1'b1;
                // An ack on the final allowed cycle still completes the access.
                if (mem_ack) begin
                    if (dmem_error) begin
                        fault        = 1'b1;
                        fault_status = STAT_ADR;
                    end else begin
                        state_next = S_WRITEBACK;
                    end
                end else if (tmo_cnt == TMO_LAST) begin
                    fault        = 1'b1;
                    fault_status = STAT_ADR;
                end else begin
                    tmo_inc = 1'b1;
                end
            end
            S_WRITEBACK: begin
                w_en       = 1'b1;
                wb_commit  = 1'b1;
                state_next = run ? S_FETCH : S_IDLE;
            end
            S_HALTED: begin
                state_next = S_HALTED;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
        if (fault) state_next = S_HALTED;
    end

    always_comb begin
        next_pc = valP;
        case (icode)
            I_CALL:  next_pc = valC;
            I_JXX:   next_pc = cnd ? valC : valP;
            I_RET:   next_pc = valM;
            default: next_pc = valP;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            PC          <= RESET_PC;
            status      <= STAT_AOK;
            cnd         <= 1'b0;
            instr_count <= '0;
        end else begin
            if (cnd_load) cnd <= cond_now;
            if (fault) status <= fault_status;
            if (wb_commit) begin
                PC          <= next_pc;
                instr_count <= instr_count + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt     <= '0;
            cycle_count <= '0;
        end else begin
            if (tmo_clear) begin
                tmo_cnt <= '0;
            end else if (tmo_inc) begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            end
            if (state != S_IDLE && state != S_HALTED) begin
                cycle_count <= cycle_count + CNT_W'(1);
            end
        end
    end

    assign halted = (state == S_HALTED);

endmodule

// File: tb/tb_seq_controller.sv
// Directed bench for seq_controller: stage walk, memory waits/timeout, branch
// conditions, fault priority, halt absorption and asynchronous reset.
module tb_seq_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic        instr_valid;
    logic        imem_error;
    logic        ZF;
    logic        SF;
    logic        OF;
    logic [63:0] valC;
    logic [63:0] valP;
    logic [63:0] valM;
    logic        mem_ack;
    logic        dmem_error;
    logic [63:0] PC;
    logic        f_en;
    logic        d_en;
    logic        e_en;
    logic        m_en;
    logic        w_en;
    logic        setcc_en;
    logic        mem_req;
    logic        cnd;
    logic [1:0]  status;
    logic        halted;
    logic [31:0] cycle_count;
    logic [31:0] instr_count;
    logic [4:0]  en;

    int n_cmp = 0;
    int n_bad = 0;

    seq_controller #(
        .RESET_PC    (64'h0),
        .MEM_TIMEOUT (16),
        .CNT_W       (32)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .run         (run),
        .icode       (icode),
        .ifun        (ifun),
        .instr_valid (instr_valid),
        .imem_error  (imem_error),
        .ZF          (ZF),
        .SF          (SF),
        .OF          (OF),
        .valC        (valC),
        .valP        (valP),
        .valM        (valM),
        .mem_ack     (mem_ack),
        .dmem_error  (dmem_error),
        .PC          (PC),
        .f_en        (f_en),
        .d_en        (d_en),
        .e_en        (e_en),
        .m_en        (m_en),
        .w_en        (w_en),
        .setcc_en    (setcc_en),
        .mem_req     (mem_req),
        .cnd         (cnd),
        .status      (status),
        .halted      (halted),
        .cycle_count (cycle_count),
        .instr_count (instr_count)
    );

    assign en = {f_en, d_en, e_en, m_en, w_en};

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; run = 1'b0; icode = 4'h0; ifun = 4'h0;
        instr_valid = 1'b1; imem_error = 1'b0; ZF = 1'b0; SF = 1'b0; OF = 1'b0;
        valC = 64'h0; valP = 64'h0; valM = 64'h0; mem_ack = 1'b0; dmem_error = 1'b0;
        tick(2);
        check("rst_pc", PC, 64'h0);
        check("rst_status", status, 2'd0);
        check("rst_en", en, 5'b00000);
        check("rst_memreq", mem_req, 1'b0);
        check("rst_cnd", cnd, 1'b0);
        check("rst_halted", halted, 1'b0);
        check("rst_cyc", cycle_count, 32'd0);
        check("rst_instr", instr_count, 32'd0);
        rst_n = 1'b1;

        // irmovq: four-cycle walk, PC updates only at end of WRITEBACK
        icode = 4'h3; valP = 64'd10; run = 1'b1;
        tick(); check("irm_f", en, 5'b10000); run = 1'b0;
        tick(); check("irm_d", en, 5'b01000);
        tick(); check("irm_e", en, 5'b00100); check("irm_setcc", setcc_en, 1'b0);
        tick(); check("irm_w", en, 5'b00001); check("irm_pc_hold", PC, 64'h0);
        tick(); check("irm_idle", en, 5'b00000); check("irm_pc", PC, 64'd10);
        check("irm_instr", instr_count, 32'd1); check("irm_cyc", cycle_count, 32'd4);

        // mrmovq with ack in the third MEMORY cycle
        icode = 4'h5; valP = 64'h14; run = 1'b1;
        tick(); run = 1'b0;
        tick(); tick();
        tick(); check("mrm_m1_req", mem_req, 1'b1); check("mrm_m1_en", en, 5'b00010);
        tick(); check("mrm_m2_req", mem_req, 1'b1);
        tick(); check("mrm_m3_req", mem_req, 1'b1); mem_ack = 1'b1;
        tick(); check("mrm_w", en, 5'b00001); check("mrm_w_req", mem_req, 1'b0);
        check("mrm_pc_hold", PC, 64'd10); mem_ack = 1'b0;
        tick(); check("mrm_pc", PC, 64'h14); check("mrm_cyc", cycle_count, 32'd11);
        check("mrm_instr", instr_count, 32'd2);

        // jle not taken, then jl taken back-to-back
        icode = 4'h7; ifun = 4'h1; ZF = 1'b0; SF = 1'b1; OF = 1'b1;
        valC = 64'h100; valP = 64'h30; run = 1'b1;
        tick(); tick();
        tick(); check("jle_setcc", setcc_en, 1'b0);
        tick(); check("jle_cnd", cnd, 1'b0);
        tick(); check("b2b_fetch", en, 5'b10000); check("jle_pc", PC, 64'h30);
        ifun = 4'h2; SF = 1'b1; OF = 1'b0; valP = 64'h40; run = 1'b0;
        tick(); tick();
        tick(); check("jl_cnd", cnd, 1'b1);
        tick(); check("jl_pc", PC, 64'h100); check("jl_instr", instr_count, 32'd4);
        check("jl_cyc", cycle_count, 32'd19);

        // OPQ raises setcc_en in EXECUTE
        icode = 4'h6; ifun = 4'h0; valP = 64'h108; run = 1'b1;
        tick(); run = 1'b0;
        tick();
        tick(); check("opq_setcc", setcc_en, 1'b1);
        tick();
        tick(); check("opq_pc", PC, 64'h108);

        // RET with ack already high (ignored until MEMORY, one-cycle access)
        icode = 4'h9; valM = 64'h40; valP = 64'h10A; mem_ack = 1'b1; run = 1'b1;
        tick(); check("ret_f", en, 5'b10000); run = 1'b0;
        tick(); tick();
        tick(); check("ret_m_req", mem_req, 1'b1);
        tick(); check("ret_w", en, 5'b00001); mem_ack = 1'b0;
        tick(); check("ret_pc", PC, 64'h40); check("ret_instr", instr_count, 32'd6);
        check("ret_cyc", cycle_count, 32'd28);

        // HALT: absorbing, run has no effect
        icode = 4'h0; valP = 64'h41; run = 1'b1;
        tick();
        tick(); check("hlt_status", status, 2'd1); check("hlt_halted", halted, 1'b1);
        check("hlt_en", en, 5'b00000); check("hlt_pc", PC, 64'h40);
        check("hlt_cyc", cycle_count, 32'd29);
        run = 1'b0; tick(); run = 1'b1; tick(3);
        check("hlt_stay", halted, 1'b1); check("hlt_stay_status", status, 2'd1);
        check("hlt_stay_pc", PC, 64'h40); check("hlt_stay_cyc", cycle_count, 32'd29);
        rst_n = 1'b0; #1;
        check("arst_pc", PC, 64'h0); check("arst_status", status, 2'd0);
        check("arst_halted", halted, 1'b0); check("arst_cyc", cycle_count, 32'd0);
        check("arst_instr", instr_count, 32'd0);
        run = 1'b0; tick(); rst_n = 1'b1;

        // invalid instruction -> INS
        icode = 4'h3; instr_valid = 1'b0; run = 1'b1;
        tick(); run = 1'b0;
        tick(); check("ins_status", status, 2'd3); check("ins_en", en, 5'b00000);
        check("ins_pc", PC, 64'h0); check("ins_cyc", cycle_count, 32'd1);
        do_reset();

        // imem_error outranks invalid instruction
        imem_error = 1'b1; run = 1'b1;
        tick(); run = 1'b0;
        tick(); check("adr_status", status, 2'd2); check("adr_halted", halted, 1'b1);
        tick(2); check("adr_en", en, 5'b00000);
        imem_error = 1'b0; instr_valid = 1'b1;
        do_reset();

        // memory timeout: 16 MEMORY cycles without ack
        icode = 4'h5; valP = 64'h50; run = 1'b1;
        tick(); run = 1'b0;
        tick(); tick();
        tick(); check("tmo_m_first", mem_req, 1'b1);
        tick(15); check("tmo_m_last", mem_req, 1'b1); check("tmo_m_last_status", status, 2'd0);
        tick(); check("tmo_status", status, 2'd2); check("tmo_halted", halted, 1'b1);
        check("tmo_req", mem_req, 1'b0); check("tmo_pc", PC, 64'h0);
        check("tmo_cyc", cycle_count, 32'd19);
        do_reset();

        // dmem_error qualified by ack -> ADR, PC preserved
        icode = 4'h3; valP = 64'h77; run = 1'b1;
        tick(); run = 1'b0;
        tick(4); check("pre_pc", PC, 64'h77);
        icode = 4'h5; valP = 64'h90; run = 1'b1;
        tick(); run = 1'b0;
        tick(); mem_ack = 1'b1; dmem_error = 1'b1;
        tick();
        tick(); check("derr_m", mem_req, 1'b1);
        tick(); check("derr_status", status, 2'd2); check("derr_pc", PC, 64'h77);
        check("derr_en", en, 5'b00000);
        mem_ack = 1'b0; dmem_error = 1'b0;
        do_reset();

        // reset asserted mid MEMORY wait
        icode = 4'h5; valP = 64'h60; run = 1'b1;
        tick(); run = 1'b0;
        tick(3);
        tick(); check("mrst_req_before", mem_req, 1'b1);
        #2; rst_n = 1'b0; #1;
        check("mrst_req", mem_req, 1'b0); check("mrst_en", en, 5'b00000);
        check("mrst_pc", PC, 64'h0); check("mrst_cyc", cycle_count, 32'd0);
        check("mrst_instr", instr_count, 32'd0);
        tick(); rst_n = 1'b1;
        tick(); check("mrst_idle", en, 5'b00000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
